// File: rtl/linear_interpolator_if.sv
// linear_interpolator_if: handshake bundle for the linear interpolating upsampler.
//   input_data/input_valid/input_ready    : sample stream into the upsampler
//   factor_set                            : requested upsampling factor N
//   output_data/output_valid/output_ready : interpolated stream out of it
// Modports:
//   slave  - the upsampler itself (consumes input stream, drives output stream)
//   master - the environment around it (drives input stream, consumes output)
interface linear_interpolator_if #(
    parameter int SIZE_DATA   = 16,
    parameter int SIZE_WINDOW = 7
) ();
    logic signed [SIZE_DATA-1:0]   input_data;
    logic                          input_valid;
    logic                          input_ready;
    logic        [SIZE_WINDOW-1:0] factor_set;
    logic signed [SIZE_DATA-1:0]   output_data;
    logic                          output_valid;
    logic                          output_ready;

    modport slave (
        input  input_data,
        input  input_valid,
        output input_ready,
        input  factor_set,
        output output_data,
        output output_valid,
        input  output_ready
    );

    modport master (
        output input_data,
        output input_valid,
        input  input_ready,
        output factor_set,
        input  output_data,
        input  output_valid,
        output output_ready
    );
endinterface

// File: rtl/linear_interpolator.sv
// linear_interpolator: power-of-two linear interpolating upsampler.
// For every new sample after the first, emits N = factor_set points on the
// straight line from the previous sample towards the new one:
//   out[k] = prev + floor(k*(cur-prev)/N), k = 0..N-1
// Ports:
//   clk   - clock
//   reset - asynchronous, active-low reset
//   bus   - linear_interpolator_if.slave (input stream, factor, output stream)
// All outputs (input_ready, output_data, output_valid) are registered.
module linear_interpolator #(
    parameter int SIZE_DATA   = 16,
    parameter int SIZE_WINDOW = 7
) (
    input  logic                  clk,
    input  logic                  reset,
    linear_interpolator_if.slave  bus
);
    localparam int DIFF_W = SIZE_DATA + 1;
    // 6 extra bits hold prev scaled by up to 64 plus the running slope sum.
    localparam int ACC_W  = SIZE_DATA + 1 + 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    // Map a factor to log2(N); anything that is not 1,2,4,..,64 behaves as N = 1.
    function automatic logic [2:0] factor_log2(input logic [SIZE_WINDOW-1:0] f);
        logic [2:0] l;
        case (f)
            SIZE_WINDOW'(1):  l = 3'd0;
            SIZE_WINDOW'(2):  l = 3'd1;
            SIZE_WINDOW'(4):  l = 3'd2;
            SIZE_WINDOW'(8):  l = 3'd3;
            SIZE_WINDOW'(16): l = 3'd4;
            SIZE_WINDOW'(32): l = 3'd5;
            SIZE_WINDOW'(64): l = 3'd6;
            default:          l = 3'd0;
        endcase
        return l;
    endfunction

    state_t                     state_r, state_s;
    logic signed [SIZE_DATA-1:0] prev_r, prev_s;
    logic signed [SIZE_DATA-1:0] cur_r, cur_s;
    logic signed [ACC_W-1:0]    acc_r, acc_s;
    logic signed [DIFF_W-1:0]   diff_r, diff_s;
    logic        [2:0]          shift_r, shift_s;
    logic        [5:0]          last_k_r, last_k_s;
    logic        [5:0]          k_r, k_s;
    logic                       input_ready_r, input_ready_s;
    logic                       output_valid_r, output_valid_s;
    logic signed [SIZE_DATA-1:0] output_data_r, output_data_s;

    logic                       hs_in_s;
    logic                       hs_out_s;
    logic        [2:0]          new_shift_s;
    logic signed [ACC_W-1:0]    prev_ext_s;
    logic signed [ACC_W-1:0]    acc_sum_s;

    assign hs_in_s     = bus.input_valid && input_ready_r;
    assign hs_out_s    = output_valid_r && bus.output_ready;
    assign new_shift_s = factor_log2(bus.factor_set);
    assign prev_ext_s  = {{(ACC_W-SIZE_DATA){prev_r[SIZE_DATA-1]}}, prev_r};
    assign acc_sum_s   = acc_r + {{(ACC_W-DIFF_W){diff_r[DIFF_W-1]}}, diff_r};

    assign bus.input_ready  = input_ready_r;
    assign bus.output_valid = output_valid_r;
    assign bus.output_data  = output_data_r;

    // Next-state and next-output logic for the IDLE/WAIT/RUN sequencer.
    always_comb begin
        state_s        = state_r;
        prev_s         = prev_r;
        cur_s          = cur_r;
        acc_s          = acc_r;
        diff_s         = diff_r;
        shift_s        = shift_r;
        last_k_s       = last_k_r;
        k_s            = k_r;
        input_ready_s  = input_ready_r;
        output_valid_s = output_valid_r;
        output_data_s  = output_data_r;

        case (state_r)
            ST_IDLE: begin
                input_ready_s = 1'b1;
                if (hs_in_s) begin
                    // First sample only primes the line start.
                    prev_s  = bus.input_data;
                    state_s = ST_WAIT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                input_ready_s = 1'b1;
                if (hs_in_s) begin
                    cur_s          = bus.input_data;
                    shift_s        = new_shift_s;
                    // 6-bit wrap makes N = 64 give 63 as well.
                    last_k_s       = (6'd1 << new_shift_s) - 6'd1;
                    acc_s          = prev_ext_s <<< new_shift_s;
                    diff_s         = {bus.input_data[SIZE_DATA-1], bus.input_data}
                                   - {prev_r[SIZE_DATA-1], prev_r};
                    k_s            = 6'd0;
                    // (prev <<< L) >>> L is prev itself: the k = 0 point.
                    output_data_s  = prev_r;
                    output_valid_s = 1'b1;
                    input_ready_s  = 1'b0;
                    state_s        = ST_RUN;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_RUN: begin
                input_ready_s = 1'b0;
                if (hs_out_s) begin
                    if (k_r == last_k_r) begin
                        // Segment done; its end point starts the next segment.
                        prev_s         = cur_r;
                        output_valid_s = 1'b0;
                        input_ready_s  = 1'b1;
                        state_s        = ST_WAIT;
                    end else begin
                        acc_s         = acc_sum_s;
                        k_s           = k_r + 6'd1;
                        output_data_s = SIZE_DATA'(acc_sum_s >>> shift_r);
                    end
                end else begin
                    state_s = ST_RUN;
                end
            end
            default: begin
                state_s        = ST_IDLE;
                input_ready_s  = 1'b0;
                output_valid_s = 1'b0;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r        <= ST_IDLE;
            prev_r         <= '0;
            cur_r          <= '0;
            acc_r          <= '0;
            diff_r         <= '0;
            shift_r        <= 3'd0;
            last_k_r       <= 6'd0;
            k_r            <= 6'd0;
            input_ready_r  <= 1'b0;
            output_valid_r <= 1'b0;
            output_data_r  <= '0;
        end else begin
            state_r        <= state_s;
            prev_r         <= prev_s;
            cur_r          <= cur_s;
            acc_r          <= acc_s;
            diff_r         <= diff_s;
            shift_r        <= shift_s;
            last_k_r       <= last_k_s;
            k_r            <= k_s;
            input_ready_r  <= input_ready_s;
            output_valid_r <= output_valid_s;
            output_data_r  <= output_data_s;
        end
    end
endmodule

// File: tb/tb_linear_interpolator.sv
// tb_linear_interpolator: directed + randomized bench for linear_interpolator.
// Expected outputs come from a line-equation model: prev + floor(k*diff/N).
module tb_linear_interpolator;
    logic clk;
    logic reset;

    linear_interpolator_if #(.SIZE_DATA(16), .SIZE_WINDOW(7)) bus ();

    linear_interpolator #(.SIZE_DATA(16), .SIZE_WINDOW(7)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    bit primed = 1'b0;
    int prev_m = 0;

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic int floordiv(input int a, input int b);
        int q;
        q = a / b;
        if ((a % b != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    function automatic int eff_n(input int f);
        if (f >= 1 && f <= 64 && ((f & (f - 1)) == 0)) return f;
        return 1;
    endfunction

    // Reference model: what one accepted sample adds to the expected stream.
    task automatic model_accept(input int d, input int f, output bit seg);
        int n;
        int diff;
        if (!primed) begin
            prev_m = d;
            primed = 1'b1;
            seg    = 1'b0;
        end else begin
            n    = eff_n(f);
            diff = d - prev_m;
            for (int k = 0; k < n; k++) exp_q.push_back(prev_m + floordiv(k * diff, n));
            prev_m = d;
            seg    = 1'b1;
        end
    endtask

    task automatic send(input int d, input int f, output bit seg);
        int waited;
        waited = 0;
        @(negedge clk);
        bus.input_data  = 16'(d);
        bus.factor_set  = 7'(f);
        bus.input_valid = 1'b1;
        while (bus.input_ready !== 1'b1 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check("in_ready_wait", bus.input_ready, 1);
        @(posedge clk);
        model_accept(d, f, seg);
        @(negedge clk);
        bus.input_valid = 1'b0;
        bus.input_data  = 16'($urandom);
        if (seg) begin
            check("seg_start_valid", bus.output_valid, 1);
            check("seg_start_ready", bus.input_ready, 0);
        end else begin
            check("prime_no_valid", bus.output_valid, 0);
            check("prime_ready", bus.input_ready, 1);
        end
    endtask

    task automatic drain(input int n, input int stall_at, input bit check_end);
        int w;
        int e;
        for (int i = 0; i < n; i++) begin
            w = 0;
            while (bus.output_valid !== 1'b1 && w < 200) begin
                @(negedge clk);
                w++;
            end
            e = (exp_q.size() > 0) ? exp_q.pop_front() : -99999;
            check("out_data", $signed(bus.output_data), e);
            if (i == stall_at) begin
                bus.output_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    check("stall_valid", bus.output_valid, 1);
                    check("stall_data", $signed(bus.output_data), e);
                    check("stall_in_ready", bus.input_ready, 0);
                end
                bus.output_ready = 1'b1;
            end
            // Factor changes mid-segment must not affect the segment.
            bus.factor_set = 7'($urandom);
            @(negedge clk);
        end
        if (check_end) begin
            check("end_valid", bus.output_valid, 0);
            check("end_in_ready", bus.input_ready, 1);
        end
    endtask

    initial begin
        bit seg;
        int f;
        int d;
        int flist[11];
        logic signed [15:0] r;
        flist = '{1, 2, 4, 8, 16, 32, 64, 0, 3, 100, 127};

        reset            = 1'b0;
        bus.input_valid  = 1'b0;
        bus.input_data   = 16'sd0;
        bus.factor_set   = 7'd4;
        bus.output_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_valid", bus.output_valid, 0);
        check("rst_data", $signed(bus.output_data), 0);
        check("rst_in_ready", bus.input_ready, 0);
        reset = 1'b1;
        #1;
        check("rel_in_ready_low", bus.input_ready, 0);
        @(negedge clk);
        check("rel_in_ready_high", bus.input_ready, 1);

        // N=4 ramp 0 -> 100, then flat 100 -> 100.
        send(0, 4, seg);
        send(100, 4, seg);
        drain(4, -1, 1'b1);
        send(100, 4, seg);
        drain(4, -1, 1'b1);
        // Negative slope uses floor.
        send(-3, 4, seg);
        drain(4, -1, 1'b1);
        // N=1 and illegal factor 3 act as a one-sample delay.
        send(5, 1, seg);
        drain(1, -1, 1'b1);
        send(7, 3, seg);
        drain(1, -1, 1'b1);
        send(9, 1, seg);
        drain(1, -1, 1'b1);
        // Full-scale swing at N=64.
        send(32767, 64, seg);
        drain(64, -1, 1'b1);
        send(-32768, 64, seg);
        drain(64, -1, 1'b1);
        // Backpressure at k=2, N=8.
        send(1000, 8, seg);
        drain(8, 2, 1'b1);
        // Reset at k=5 of an N=8 segment.
        send(-500, 8, seg);
        drain(5, -1, 1'b0);
        check("pre_reset_k5", $signed(bus.output_data), exp_q[0]);
        reset = 1'b0;
        #1;
        check("midrst_valid", bus.output_valid, 0);
        check("midrst_data", $signed(bus.output_data), 0);
        check("midrst_in_ready", bus.input_ready, 0);
        exp_q.delete();
        primed = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        send(1234, 2, seg);
        send(-1234, 2, seg);
        drain(2, -1, 1'b1);

        // Randomized segments with legal and illegal factors.
        for (int t = 0; t < 24; t++) begin
            f = flist[$urandom_range(0, 10)];
            r = 16'($urandom);
            d = r;
            send(d, f, seg);
            if (seg) drain(eff_n(f), (($urandom_range(0, 3) == 0) ? 0 : -1), 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
